// File: rtl/pool_pkg.sv
// Shared pooling definitions: pixel width and signed pixel type.
package pool_pkg;
  localparam int DATA_W = 22;
  typedef logic signed [DATA_W-1:0] pix_t;
endpackage

// File: rtl/partial_pooling.sv
// Combinational signed max of two pixels.
module partial_pooling #(
  parameter int DATA_W = pool_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_out
);
  // Ties pick data_0; both operands are identical then.
  assign data_out = ($signed(data_1) > $signed(data_0)) ? data_1 : data_0;
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool: pairs pixels horizontally, keeps one
// row of pair maxima and emits one pooled value per window.
module maxpool2x2_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LBN = IMG_W / 2;
  localparam int LAW = (LBN > 1) ? $clog2(LBN) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] first;
  logic [DATA_W-1:0] linebuf [LBN];

  logic              accept;
  logic              col_end, row_end;
  logic              pair_done, win_done;
  logic [LAW-1:0]    lb_idx;
  logic [DATA_W-1:0] lb_rd, hmax, vmax;

  // Uniform stall: nothing advances while an unaccepted result is held.
  assign i_ready   = !o_valid || o_ready;
  assign accept    = i_valid && i_ready;
  assign col_end   = (col == CW'(IMG_W - 1));
  assign row_end   = (row == RW'(IMG_H - 1));
  assign pair_done = accept && col[0];
  assign win_done  = pair_done && row[0];
  assign lb_idx    = LAW'(col >> 1);
  assign lb_rd     = linebuf[lb_idx];

  partial_pooling #(.DATA_W(DATA_W)) u_hmax (
    .data_0   (first),
    .data_1   (i_data),
    .data_out (hmax)
  );

  partial_pooling #(.DATA_W(DATA_W)) u_vmax (
    .data_0   (lb_rd),
    .data_1   (hmax),
    .data_out (vmax)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first <= '0;
    end else if (accept && !col[0]) begin
      first <= i_data;
    end
  end

  // Even rows park their pair maxima for the odd row beneath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LBN; i++) linebuf[i] <= '0;
    end else if (pair_done && !row[0]) begin
      linebuf[lb_idx] <= hmax;
    end
  end

  // Reload takes priority over drain so a same-cycle hand-off has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (win_done) begin
      o_valid <= 1'b1;
      o_data  <= vmax;
      o_last  <= row_end && col_end;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: 4x4 frames plus random 8x8 frames.
module tb_maxpool2x2_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b1, ol4;
  logic [21:0] id4 = '0, od4;
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, ol8;
  logic [21:0] id8 = '0, od8;

  maxpool2x2_stream #(.DATA_W(22), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv4), .i_ready(ir4), .i_data(id4),
    .o_valid(ov4), .o_ready(or4), .o_data(od4), .o_last(ol4));

  maxpool2x2_stream #(.DATA_W(22), .IMG_W(8), .IMG_H(8)) u8 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv8), .i_ready(ir8), .i_data(id8),
    .o_valid(ov8), .o_ready(or8), .o_data(od8), .o_last(ol8));

  int checks = 0;
  int errs   = 0;
  logic [22:0] q4[$];
  logic [22:0] q8[$];

  // Inputs change only just after posedge, so negedge samples are stable.
  always @(negedge clk) begin
    if (ov4 && or4) q4.push_back({ol4, od4});
    if (ov8 && or8) q8.push_back({ol8, od8});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send4(input logic [21:0] v);
    int n;
    n = 0;
    iv4 = 1'b1;
    id4 = v;
    @(negedge clk);
    while (!ir4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send4_ready", {31'b0, ir4}, 32'd1);
    @(posedge clk);
    #1;
    iv4 = 1'b0;
  endtask

  task automatic flush4();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q4(input string tag, input logic [21:0] e0, input logic [21:0] e1,
                        input logic [21:0] e2, input logic [21:0] e3);
    logic [21:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, q4.size(), 32'd4);
    for (int i = 0; i < 4 && i < q4.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), {10'b0, q4[i][21:0]}, {10'b0, e[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'b0, q4[i][22]}, {31'b0, (i == 3)});
    end
  endtask

  logic [21:0] negf [16];
  logic signed [21:0] pix [128];
  logic [21:0] expv [32];

  initial begin
    logic signed [21:0] m;
    logic acc;
    int idx, nlast, cyc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", {31'b0, ov4}, 32'd0);
    chk("rst_odata", {10'b0, od4}, 32'd0);
    chk("rst_olast", {31'b0, ol4}, 32'd0);
    chk("rst_iready", {31'b0, ir4}, 32'd1);
    rst_n = 1'b1;

    // Frame 1: ramp 0..15, latency and o_last placement
    q4.delete();
    for (int p = 0; p < 16; p++) begin
      send4(22'(p));
      chk($sformatf("f1_vld_p%0d", p), {31'b0, ov4},
          {31'b0, (p == 5 || p == 7 || p == 13 || p == 15)});
      if (p == 5 || p == 7 || p == 13 || p == 15) begin
        chk($sformatf("f1_data_p%0d", p), {10'b0, od4}, 32'(p));
        chk($sformatf("f1_last_p%0d", p), {31'b0, ol4}, {31'b0, (p == 15)});
      end
    end
    flush4();
    chk_q4("f1", 22'd5, 22'd7, 22'd13, 22'd15);

    // Frame 2: negative extremes
    negf = '{22'h3FFFFD, 22'h3FFFF8, 22'h200000, 22'h200000,
             22'h3FFFFF, 22'h217B80, 22'h200000, 22'h200000,
             22'd1, 22'd2, 22'd3, 22'd4,
             22'd5, 22'd6, 22'd7, 22'd8};
    q4.delete();
    for (int p = 0; p < 16; p++) send4(negf[p]);
    flush4();
    chk_q4("neg", 22'h3FFFFF, 22'h200000, 22'd6, 22'd8);

    // Frame 3: 5-cycle stall after the first output
    q4.delete();
    for (int p = 0; p < 6; p++) send4(22'(p));
    or4 = 1'b0;
    iv4 = 1'b1;
    id4 = 22'd6;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("bp_iready%0d", s), {31'b0, ir4}, 32'd0);
      chk($sformatf("bp_ovalid%0d", s), {31'b0, ov4}, 32'd1);
      chk($sformatf("bp_odata%0d", s), {10'b0, od4}, 32'd5);
    end
    @(posedge clk);
    #1;
    or4 = 1'b1;
    for (int p = 6; p < 16; p++) send4(22'(p));
    flush4();
    chk_q4("bp", 22'd5, 22'd7, 22'd13, 22'd15);

    // Frame 4: reset after pixel 9, then a clean frame
    for (int p = 0; p < 10; p++) send4(22'(p));
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ovalid", {31'b0, ov4}, 32'd0);
    chk("mid_rst_odata", {10'b0, od4}, 32'd0);
    chk("mid_rst_olast", {31'b0, ol4}, 32'd0);
    chk("mid_rst_iready", {31'b0, ir4}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q4.delete();
    for (int p = 0; p < 16; p++) send4(22'(p));
    flush4();
    chk_q4("mid", 22'd5, 22'd7, 22'd13, 22'd15);

    // Two back-to-back 8x8 frames, random data and handshakes
    for (int i = 0; i < 128; i++) pix[i] = 22'($random);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          m = pix[f*64 + (2*r)*8 + 2*c];
          if (pix[f*64 + (2*r)*8 + 2*c + 1] > m) m = pix[f*64 + (2*r)*8 + 2*c + 1];
          if (pix[f*64 + (2*r+1)*8 + 2*c] > m) m = pix[f*64 + (2*r+1)*8 + 2*c];
          if (pix[f*64 + (2*r+1)*8 + 2*c + 1] > m) m = pix[f*64 + (2*r+1)*8 + 2*c + 1];
          expv[f*16 + r*4 + c] = m;
        end
    q8.delete();
    idx = 0;
    for (cyc = 0; cyc < 5000 && (idx < 128 || q8.size() < 32); cyc++) begin
      or8 = ($urandom_range(0, 3) != 0);
      if (!iv8) begin
        if (idx < 128 && $urandom_range(0, 2) != 0) begin
          iv8 = 1'b1;
          id8 = pix[idx];
        end else begin
          id8 = 22'($urandom);
        end
      end
      @(negedge clk);
      acc = iv8 && ir8;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        iv8 = 1'b0;
      end
    end
    chk("r8_inputs", idx, 32'd128);
    chk("r8_count", q8.size(), 32'd32);
    nlast = 0;
    for (int i = 0; i < 32 && i < q8.size(); i++) begin
      chk($sformatf("r8_data%0d", i), {10'b0, q8[i][21:0]}, {10'b0, expv[i]});
      chk($sformatf("r8_last%0d", i), {31'b0, q8[i][22]}, {31'b0, (i == 15 || i == 31)});
      if (q8[i][22]) nlast++;
    end
    chk("r8_nlast", nlast, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2x2/stride-2 signed max-pooling stage placed between the convolution output stream and the next layer. Accepts one raster-order pixel per cycle over a valid/ready handshake, forms horizontal pairs and reduces them with the existing combinational `partial_pooling` max. It buffers one row of pair maxima and emits one pooled value per 2x2 window. This block is the producer and sequencer that feeds `partial_pooling` its `{data_1, data_0}` pairs.

## Interface
- `DATA_W`, 22: signed pixel width; must match `partial_pooling`.
- `IMG_W`, 8: input row width in pixels; even, at least 2.
- `IMG_H`, 8: input rows per frame; even, at least 2.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: input pixel valid.
- `i_ready` output 1: block can accept a pixel this cycle.
- `i_data` input `DATA_W`: signed input pixel, in raster order.
- `o_valid` output 1: pooled value valid.
- `o_ready` input 1: downstream accepts the pooled value.
- `o_data` output `DATA_W`: signed pooled maximum.
- `o_last` output 1: marks the final pooled value of a frame.

## Operation
- A transfer occurs when `i_valid && i_ready`. An output transfer occurs when `o_valid && o_ready`.
- Counters:
  - `col` runs 0..`IMG_W`-1.
  - `row` runs 0..`IMG_H`-1.
  - Both advance only on input transfers. `col` wraps to 0 and increments `row`; `row` wraps to 0 at the end of the frame.
- Even `col`: the pixel is stored in the pair register `first`.
- Odd `col`: compute `hmax = max(first, i_data)` through `partial_pooling` with `data_0 = first` and `data_1 = i_data`.
  - Compare is signed. On a tie, either operand is acceptable because the two values are identical.
- Even `row`, odd `col`: write `hmax` into line buffer entry `col>>1`. The line buffer holds `IMG_W/2` entries.
- Odd `row`, odd `col`: load the output register with `max(linebuf[col>>1], hmax)` through a second `partial_pooling` instance.
  - Set `o_valid`.
  - Set `o_last` when `row == IMG_H-1` and `col == IMG_W-1`.
- Output register:
  - It holds `o_data`/`o_last` stable while `o_valid && !o_ready`.
  - It clears `o_valid` on an output transfer unless it is reloaded in the same cycle.
- `i_ready = !o_valid || o_ready`, applied uniformly to every pixel. This keeps counters and buffers in lockstep under backpressure.
- Simultaneous output transfer and new window completion: the register is reloaded and `o_valid` stays 1. No bubble and no loss.
- No width growth: max of signed `DATA_W` values is `DATA_W`.
- There is no frame-start input. Frame alignment depends solely on reset and the counter wrap.

## Timing
- Reset values:
  - `o_valid`, `o_data`, `o_last`, `col`, `row`, `first` and the line buffer are all 0.
  - `i_ready` reads 1 out of reset.
- Latency: `o_valid` rises on the clock edge that accepts the bottom-right pixel of a window, so the value is visible the next cycle. Latency is 1 cycle.
- Throughput: one input per cycle with `o_ready` held high. One output every 2 cycles during odd rows; no outputs during even rows.
- Backpressure: while `o_valid && !o_ready`, `i_ready` is 0 and no state changes.
- Reset mid-frame discards any partial window and buffered row. The next pixel accepted is treated as row 0, col 0.
- Back-to-back frames: after the wrap, the next frame starts with no idle cycle.
- `i_data` is ignored when `i_valid` is 0. Counters never advance without a transfer.

## Structure
- Shared package `pool_pkg` holds `DATA_W` (22) and the signed pixel typedef.
- Counter widths are derived locally with `$clog2` of `IMG_W` and `IMG_H`.
- Sub-module: the existing combinational `partial_pooling`, instantiated twice (horizontal max and vertical max).
- The line buffer is a register array, not a macro.

## Test plan
- 4x4 frame (`IMG_W=IMG_H=4`), pixels 0..15 in raster order, `o_ready=1` → outputs 5, 7, 13, 15; `o_last` is set only with 15; each `o_valid` appears 1 cycle after pixels 5, 7, 13, 15 are accepted.
- Negative values: window {-3, -8, -1, -2000000} → 0x3FFFFF (-1). Window {-2097152, -2097152, -2097152, -2097152} → 0x200000.
- Backpressure: hold `o_ready=0` for 5 cycles after the first output → `i_ready=0` for those 5 cycles, `o_data` stable, no pixel lost, and the output sequence is the same as the no-stall run.
- Reset mid-frame: deassert `rst_n` after pixel 9 of a 4x4 frame, then stream 0..15 → outputs are again exactly 5, 7, 13, 15 with reset outputs 0.
- Two back-to-back 8x8 frames driven with random `$random` pixels and random `i_valid`/`o_ready` → all 32 outputs match a behavioural 2x2 signed-max model; exactly two `o_last` pulses.
